// File: rtl/cpu_bus_master_pkg.sv
// Shared C1 bus definitions for the CPU-side master: command codes, bus widths,
// master FSM states and command classification helpers.
package cpu_bus_master_pkg;

    localparam int ADDR_W   = 19;
    localparam int OFFSET_W = 4;
    localparam int ADDR1_W  = ADDR_W - OFFSET_W;
    localparam int DATA1_W  = 16;
    localparam int TIMER_W  = 10;
    localparam logic [TIMER_W-1:0] TIMEOUT = 10'd1023;

    typedef enum logic [2:0] {
        C1_NOP     = 3'd0,
        C1_READ8   = 3'd1,
        C1_READ16  = 3'd2,
        C1_READ32  = 3'd3,
        C1_INV     = 3'd4,
        C1_WRITE8  = 3'd5,
        C1_WRITE16 = 3'd6,
        C1_WRITE32 = 3'd7
    } c1_cmd_t;

    // The slave's response reuses the WRITE32 code; bus ownership tells them apart.
    localparam c1_cmd_t C1_RESPONSE = C1_WRITE32;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR_HI  = 4'd1,
        ST_ADDR_LO  = 4'd2,
        ST_WDATA2   = 4'd3,
        ST_END_WR   = 4'd4,
        ST_RELEASE  = 4'd5,
        ST_WAIT_RSP = 4'd6,
        ST_RDATA2   = 4'd7,
        ST_RECLAIM  = 4'd8,
        ST_RESP     = 4'd9
    } state_t;

    function automatic logic cmd_is_legal(input logic [2:0] cmd);
        logic legal_s;
        case (cmd)
            C1_NOP, C1_INV: legal_s = 1'b0;
            default:        legal_s = 1'b1;
        endcase
        return legal_s;
    endfunction

    function automatic logic cmd_is_write(input logic [2:0] cmd);
        logic write_s;
        case (cmd)
            C1_WRITE8, C1_WRITE16, C1_WRITE32: write_s = 1'b1;
            default:                           write_s = 1'b0;
        endcase
        return write_s;
    endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// CPU request/response channel of the C1 bus master. The requester (CPU) uses
// the master modport; the bus master block itself uses the slave modport.
interface cpu_bus_master_if;
    import cpu_bus_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_cmd, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/cpu_bus_master.sv
// CPU-side C1 bus master: turns one parallel request into the two-cycle address,
// 16-bit data beat, turnaround and response-wait sequence of the C1 bus.
module cpu_bus_master
    import cpu_bus_master_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    cpu_bus_master_if.slave     req_if,
    output logic [ADDR1_W-1:0]  addr_cpu_w,
    inout  wire  [DATA1_W-1:0]  data_cpu_w,
    inout  wire  [2:0]          cmd_cpu_w
);

    state_t              state_r;
    logic                owner_r;
    c1_cmd_t             cmd_r;
    logic [ADDR1_W-1:0]  addr_r;
    logic [DATA1_W-1:0]  data_r;
    logic                req_ready_r;
    logic                rsp_valid_r;
    logic [31:0]         rsp_rdata_r;
    logic                rsp_err_r;
    logic [TIMER_W-1:0]  timer_r;
    c1_cmd_t             op_cmd_r;
    logic [ADDR_W-1:0]   op_addr_r;
    logic [31:0]         op_wdata_r;
    logic [31:0]         rdata_r;
    logic                err_r;

    // Data and command wires are only driven while the master owns the bus.
    assign data_cpu_w = owner_r ? data_r : {DATA1_W{1'bz}};
    assign cmd_cpu_w  = owner_r ? cmd_r  : 3'bzzz;
    assign addr_cpu_w = addr_r;

    assign req_if.req_ready = req_ready_r;
    assign req_if.rsp_valid = rsp_valid_r;
    assign req_if.rsp_rdata = rsp_rdata_r;
    assign req_if.rsp_err   = rsp_err_r;

    // Transaction FSM: every bus and response output is set on the edge entering its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            owner_r     <= 1'b1;
            cmd_r       <= C1_NOP;
            addr_r      <= {ADDR1_W{1'b0}};
            data_r      <= {DATA1_W{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            timer_r     <= {TIMER_W{1'b0}};
            op_cmd_r    <= C1_NOP;
            op_addr_r   <= {ADDR_W{1'b0}};
            op_wdata_r  <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_if.req_valid && req_ready_r) begin
                        op_cmd_r    <= c1_cmd_t'(req_if.req_cmd);
                        op_addr_r   <= req_if.req_addr;
                        op_wdata_r  <= req_if.req_wdata;
                        rdata_r     <= 32'h0000_0000;
                        err_r       <= 1'b0;
                        req_ready_r <= 1'b0;
                        if (cmd_is_legal(req_if.req_cmd)) begin
                            cmd_r   <= c1_cmd_t'(req_if.req_cmd);
                            addr_r  <= req_if.req_addr[ADDR_W-1:OFFSET_W];
                            state_r <= ST_ADDR_HI;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                            rsp_err_r   <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_ADDR_HI: begin
                    addr_r <= {{(ADDR1_W-OFFSET_W){1'b0}}, op_addr_r[OFFSET_W-1:0]};
                    if (cmd_is_write(op_cmd_r)) begin
                        data_r <= op_wdata_r[15:0];
                    end else begin
                        data_r <= {DATA1_W{1'b0}};
                    end
                    state_r <= ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    case (op_cmd_r)
                        C1_WRITE32: begin
                            data_r  <= op_wdata_r[31:16];
                            state_r <= ST_WDATA2;
                        end
                        C1_WRITE8, C1_WRITE16: begin
                            cmd_r   <= C1_NOP;
                            state_r <= ST_END_WR;
                        end
                        default: begin
                            owner_r <= 1'b0;
                            cmd_r   <= C1_NOP;
                            timer_r <= {TIMER_W{1'b0}};
                            state_r <= ST_RELEASE;
                        end
                    endcase
                end
                ST_WDATA2: begin
                    cmd_r   <= C1_NOP;
                    state_r <= ST_END_WR;
                end
                ST_END_WR: begin
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                    state_r     <= ST_RESP;
                end
                ST_RELEASE: begin
                    state_r <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    // An undriven or unknown command never compares equal to RESPONSE.
                    if (cmd_cpu_w == C1_RESPONSE) begin
                        rdata_r[15:0] <= (op_cmd_r == C1_READ8) ? {8'h00, data_cpu_w[7:0]} : data_cpu_w;
                        state_r       <= (op_cmd_r == C1_READ32) ? ST_RDATA2 : ST_RECLAIM;
                    end else if (timer_r == TIMEOUT) begin
                        err_r   <= 1'b1;
                        state_r <= ST_RECLAIM;
                    end else begin
                        timer_r <= timer_r + 10'd1;
                    end
                end
                ST_RDATA2: begin
                    rdata_r[31:16] <= data_cpu_w;
                    state_r        <= ST_RECLAIM;
                end
                ST_RECLAIM: begin
                    owner_r     <= 1'b1;
                    cmd_r       <= C1_NOP;
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= rdata_r;
                    rsp_err_r   <= err_r;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    owner_r     <= 1'b1;
                    cmd_r       <= C1_NOP;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master with a behavioural C1 slave (16-byte line,
// configurable response delay) and a response scoreboard.
module tb_cpu_bus_master;
    import cpu_bus_master_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_master_if bus_if();

    logic [ADDR1_W-1:0] addr_bus;
    wire  [DATA1_W-1:0] data_bus;
    wire  [2:0]         cmd_bus;

    logic        slv_drive = 1'b0;
    logic [15:0] slv_data  = 16'h0000;
    logic [2:0]  slv_cmd   = 3'd0;
    assign data_bus = slv_drive ? slv_data : 16'hzzzz;
    assign cmd_bus  = slv_drive ? slv_cmd  : 3'bzzz;

    cpu_bus_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_if     (bus_if),
        .addr_cpu_w (addr_bus),
        .data_cpu_w (data_bus),
        .cmd_cpu_w  (cmd_bus)
    );

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    // Slave model state
    int          slv_phase = 0;
    int          slv_cnt   = 0;
    int          slv_delay = 3;
    logic        slv_force_en = 1'b0;
    logic [15:0] slv_force_data = 16'h0000;
    logic [7:0]  slv_line [16];
    logic [2:0]  slv_op = 3'd0;
    logic [3:0]  slv_lo = 4'd0;
    logic [14:0] seen_hi = 15'd0;
    logic [3:0]  seen_lo = 4'd0;
    logic [15:0] seen_b1 = 16'd0;
    logic [15:0] seen_b2 = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural C1 slave: samples the bus on negedge, answers reads after slv_delay negedges.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            slv_phase = 0;
            slv_drive = 1'b0;
            slv_cmd   = 3'd0;
        end else begin
            case (slv_phase)
                0: if (!$isunknown(cmd_bus) && cmd_is_legal(cmd_bus)) begin
                    slv_op    = cmd_bus;
                    seen_hi   = addr_bus;
                    slv_phase = 1;
                end
                1: begin
                    slv_lo  = addr_bus[3:0];
                    seen_lo = slv_lo;
                    if (cmd_is_write(slv_op)) begin
                        seen_b1 = data_bus;
                        slv_line[slv_lo] = data_bus[7:0];
                        if (slv_op != C1_WRITE8) slv_line[4'(slv_lo + 4'd1)] = data_bus[15:8];
                        slv_phase = (slv_op == C1_WRITE32) ? 2 : 0;
                    end else begin
                        slv_cnt   = 1;
                        slv_phase = 3;
                    end
                end
                2: begin
                    seen_b2 = data_bus;
                    slv_line[4'(slv_lo + 4'd2)] = data_bus[7:0];
                    slv_line[4'(slv_lo + 4'd3)] = data_bus[15:8];
                    slv_phase = 0;
                end
                3: if (slv_delay != 0 && slv_cnt >= slv_delay) begin
                    slv_drive = 1'b1;
                    slv_cmd   = C1_RESPONSE;
                    slv_data  = slv_force_en ? slv_force_data
                                             : {slv_line[4'(slv_lo + 4'd1)], slv_line[slv_lo]};
                    slv_phase = (slv_op == C1_READ32) ? 4 : 5;
                end else begin
                    slv_cnt++;
                end
                4: begin
                    slv_data  = {slv_line[4'(slv_lo + 4'd3)], slv_line[4'(slv_lo + 4'd2)]};
                    slv_phase = 5;
                end
                default: begin
                    slv_drive = 1'b0;
                    slv_cmd   = 3'd0;
                    slv_phase = 0;
                end
            endcase
        end
    end

    // Contention monitor: the slave must never drive while the master still owns the wires.
    always @(clk) begin
        #2;
        if (!reset && slv_drive && dut.owner_r) overlap_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic do_req(input string tag, input logic [2:0] cmd, input logic [18:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int lat_lo, input int lat_hi);
        int   cyc;
        logic got;
        logic nop_ok;
        exp_t e;
        sb.push_back('{exp_rdata, exp_err});
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_cmd   = cmd;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        nop_ok = 1'b1;
        while (!got && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy_ready"}, {31'd0, bus_if.req_ready}, 32'd0);
            if (cmd_bus !== 3'd0) nop_ok = 1'b0;
            if (bus_if.rsp_valid === 1'b1) got = 1'b1;
        end
        check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            checks++;
            assert (cyc >= lat_lo && cyc <= lat_hi) else begin
                errors++;
                $error("FAIL %s_latency: observed %0d cycles, expected %0d..%0d", tag, cyc, lat_lo, lat_hi);
            end
            check({tag, "_sb_nonempty"}, {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_rdata"}, bus_if.rsp_rdata, e.rdata);
                check({tag, "_err"}, {31'd0, bus_if.rsp_err}, {31'd0, e.err});
            end
            if (!cmd_is_legal(cmd)) check({tag, "_bus_nop"}, {31'd0, nop_ok}, 32'd1);
            @(negedge clk);
            check({tag, "_one_cycle"}, {31'd0, bus_if.rsp_valid}, 32'd0);
            check({tag, "_ready_again"}, {31'd0, bus_if.req_ready}, 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) slv_line[i] = 8'h00;
        bus_if.req_valid = 1'b0;
        bus_if.req_cmd   = 3'd0;
        bus_if.req_addr  = 19'd0;
        bus_if.req_wdata = 32'd0;

        #1 reset = 1'b1;
        #3;
        check("rst_ready",  {31'd0, bus_if.req_ready}, 32'd1);
        check("rst_valid",  {31'd0, bus_if.rsp_valid}, 32'd0);
        check("rst_rdata",  bus_if.rsp_rdata, 32'd0);
        check("rst_err",    {31'd0, bus_if.rsp_err}, 32'd0);
        check("rst_addr",   {17'd0, addr_bus}, 32'd0);
        check("rst_cmd",    {29'd0, cmd_bus}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_req("wr32", C1_WRITE32, 19'h2A4B4, 32'h99EE_FFFF, 32'h0, 1'b0, 5, 5);
        check("wr32_hi", {17'd0, seen_hi}, 32'h2A4B);
        check("wr32_lo", {28'd0, seen_lo}, 32'h4);
        check("wr32_b1", {16'd0, seen_b1}, 32'hFFFF);
        check("wr32_b2", {16'd0, seen_b2}, 32'h99EE);

        slv_delay = 3;
        do_req("rd32", C1_READ32, 19'h2A4B4, 32'h0, 32'h99EE_FFFF, 1'b0, 4, 20);

        slv_delay = 2; slv_force_en = 1'b1; slv_force_data = 16'hABCD;
        do_req("rd8_mask", C1_READ8, 19'h2A4B5, 32'h0, 32'h0000_00CD, 1'b0, 4, 20);
        slv_force_en = 1'b0;

        slv_delay = 4;
        do_req("rd16", C1_READ16, 19'h2A4B6, 32'h0, 32'h0000_99EE, 1'b0, 4, 20);

        do_req("wr8", C1_WRITE8, 19'h2A4B0, 32'h1234_565A, 32'h0, 1'b0, 4, 4);
        check("wr8_b1", {16'd0, seen_b1}, 32'h565A);
        slv_delay = 2;
        do_req("rd8", C1_READ8, 19'h2A4B0, 32'h0, 32'h0000_005A, 1'b0, 4, 20);

        do_req("inv", C1_INV, 19'h2A4B4, 32'h0, 32'h0, 1'b1, 1, 1);
        do_req("nop_cmd", C1_NOP, 19'h00001, 32'h0, 32'h0, 1'b1, 1, 1);

        slv_delay = 0;
        do_req("timeout", C1_READ16, 19'h00010, 32'h0, 32'h0, 1'b1, int'(TIMEOUT), int'(TIMEOUT) + 12);
        check("timeout_cmd_nop", {29'd0, cmd_bus}, 32'd0);

        // Abort a read stuck in the response wait with an asynchronous reset.
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_cmd   = C1_READ16;
        bus_if.req_addr  = 19'h7FFF3;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check("mid_rst_rdata", bus_if.rsp_rdata, 32'd0);
        check("mid_rst_err",   {31'd0, bus_if.rsp_err}, 32'd0);
        check("mid_rst_addr",  {17'd0, addr_bus}, 32'd0);
        check("mid_rst_cmd",   {29'd0, cmd_bus}, 32'd0);
        check("mid_rst_data",  {16'd0, data_bus}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_hold_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        end
        reset = 1'b0;

        do_req("post_rst_wr16", C1_WRITE16, 19'h00012, 32'hABCD_1234, 32'h0, 1'b0, 4, 4);
        check("post_rst_hi", {17'd0, seen_hi}, 32'h1);
        check("post_rst_lo", {28'd0, seen_lo}, 32'h2);
        check("post_rst_b1", {16'd0, seen_b1}, 32'h1234);

        check("no_bus_overlap", overlap_cnt, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
